// File: rtl/scroll_scheduler.sv
// -----------------------------------------------------------------------------
// scroll_scheduler
//
// Purpose:
//   Two independent engines driven by the end-of-frame pulse:
//   * Scroll logic: a doodle landing high enough (move_collision on
//     frame_tick) starts a world scroll that lasts FRAMES_PER_SCROLL frames.
//     Each scrolling frame produces one shift_en pulse for the platform
//     datapath. Collisions during a scroll are ignored.
//   * Recycle FSM (IDLE/SCAN/WAIT_RND/ISSUE): once per frame it scans the
//     platform row groups. Each group that has fallen to EARTH or below is
//     re-issued with a fresh activation pattern taken from the LFSR, over a
//     valid/ready handshake.
//
// Optional feature (macro SCROLL_STATS_EN):
//   When defined, adds output scroll_count. This is a 16-bit saturating count
//   of scroll triggers. When undefined, the port and the counter are absent.
//
// Ports:
//   clk            in   system clock, all state on the rising edge
//   rst            in   asynchronous active-low reset
//   frame_tick     in   one-cycle pulse at the end of each frame
//   move_collision in   scroll request, only looked at on frame_tick
//   group_y        in   GROUPS x signed 11-bit y of each group's first platform
//   rnd, rnd_valid in   LFSR pattern (15 bit) and its valid flag
//   shift_en       out  one-cycle pulse: datapath applies the world shift
//   scrolling      out  high while a scroll is in progress
//   recycle_valid  out  recycle request valid
//   recycle_ready  in   recycle request accepted
//   recycle_group  out  index of the group being recycled
//   recycle_mask   out  new activation pattern for that group (never zero)
//   overrun        out  sticky: a frame_tick arrived while the FSM was busy
//   scroll_count   out  (SCROLL_STATS_EN only) saturating trigger count
// -----------------------------------------------------------------------------
module scroll_scheduler #(
    parameter int FRAMES_PER_SCROLL = 16,
    parameter int GROUPS            = 6,
    parameter int EARTH             = 768
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               move_collision,
    input  logic signed [10:0] group_y [GROUPS],
    input  logic [14:0]        rnd,
    input  logic               rnd_valid,
    output logic               shift_en,
    output logic               scrolling,
    output logic               recycle_valid,
    input  logic               recycle_ready,
    output logic [2:0]         recycle_group,
    output logic [14:0]        recycle_mask,
    output logic               overrun
`ifdef SCROLL_STATS_EN
    ,
    output logic [15:0]        scroll_count
`endif
);

    // ---------------------------------------------------------------------
    // Scroll logic
    // ---------------------------------------------------------------------
    localparam int FW = $clog2(FRAMES_PER_SCROLL + 1);
    localparam logic [FW-1:0] FRAMES_LAST = FW'(FRAMES_PER_SCROLL - 1);

    logic [FW-1:0] frames_left;
    logic          trigger;

    // A new scroll may only start once the previous one has fully drained.
    assign trigger   = frame_tick && (frames_left == '0) && move_collision;
    assign scrolling = (frames_left != '0);

    // The triggering frame gives the first pulse. Loading FRAMES_PER_SCROLL-1
    // then yields exactly FRAMES_PER_SCROLL pulses in total.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_left <= '0;
            shift_en    <= 1'b0;
        end else begin
            shift_en <= 1'b0;
            if (frame_tick) begin
                if (frames_left != '0) begin
                    frames_left <= frames_left - FW'(1);
                    shift_en    <= 1'b1;
                end else if (move_collision) begin
                    frames_left <= FRAMES_LAST;
                    shift_en    <= 1'b1;
                end
            end
        end
    end

`ifdef SCROLL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scroll_count <= 16'h0000;
        end else if (trigger && (scroll_count != 16'hFFFF)) begin
            scroll_count <= scroll_count + 16'h0001;
        end
    end
`else
    logic unused_trigger;
    assign unused_trigger = trigger;
`endif

    // ---------------------------------------------------------------------
    // Recycle FSM
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, SCAN, WAIT_RND, ISSUE} state_t;

    localparam logic signed [10:0] EARTH_Y  = 11'(EARTH);
    localparam logic [2:0]         IDX_LAST = 3'(GROUPS - 1);

    state_t      state, state_next;
    logic [2:0]  idx, idx_next;
    logic        settle, settle_next;
    logic [2:0]  group_next;
    logic [14:0] mask_next;
    logic        overrun_next;

    // Pad the group inputs out to the full 3-bit index range. An idx value
    // beyond GROUPS-1 can then never select outside the array.
    logic signed [10:0] gy_pad [8];
    logic signed [10:0] gy_sel;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
        if (gi < GROUPS) begin : g_live
            assign gy_pad[gi] = group_y[gi];
        end else begin : g_tie
            assign gy_pad[gi] = '0;
        end
    end

    assign gy_sel        = gy_pad[idx];
    assign recycle_valid = (state == ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= 3'd0;
            settle        <= 1'b0;
            recycle_group <= 3'd0;
            recycle_mask  <= 15'h0000;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            idx           <= idx_next;
            settle        <= settle_next;
            recycle_group <= group_next;
            recycle_mask  <= mask_next;
            overrun       <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        settle_next  = settle;
        group_next   = recycle_group;
        mask_next    = recycle_mask;
        overrun_next = overrun;

        // A tick that finds the FSM busy is lost for recycling. It still
        // reaches the scroll logic, which looks at frame_tick on its own.
        if (frame_tick && (state != IDLE)) begin
            overrun_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_next  = SCAN;
                    idx_next    = 3'd0;
                    settle_next = 1'b1;
                end
            end
            SCAN: begin
                // One idle cycle on entry. shift_en lands the cycle after
                // frame_tick and the datapath updates y on the following
                // edge, so group_y is first compared two edges after the
                // tick.
                if (settle) begin
                    settle_next = 1'b0;
                end else if (gy_sel >= EARTH_Y) begin
                    state_next = WAIT_RND;
                    group_next = idx;
                end else if (idx == IDX_LAST) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx + 3'd1;
                end
            end
            WAIT_RND: begin
                if (rnd_valid) begin
                    // An all-zero pattern would leave the row empty, so
                    // force a single platform instead.
                    mask_next  = (rnd == 15'h0000) ? 15'h4000 : rnd;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (recycle_ready) begin
                    if (idx == IDX_LAST) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + 3'd1;
                        state_next = SCAN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_scroll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_scroll_scheduler
//
// Self-checking bench for scroll_scheduler (default parameters).
// Every cycle the bench pushes the expected shift_en/scrolling values for the
// next edge into a queue. It pops and compares them once the DUT has updated.
// Expected recycle requests are queued when the group_y stimulus is set up.
// They are popped on every valid&ready handshake. A table of single-scan
// recycle vectors is applied in a loop. Hand-written sequences cover the
// multi-frame scroll, the handshake stall, overrun and reset aborts.
// -----------------------------------------------------------------------------
module tb_scroll_scheduler;

    localparam int F = 16;
    localparam int G = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_tick;
    logic               move_collision;
    logic signed [10:0] group_y [G];
    logic [14:0]        rnd;
    logic               rnd_valid;
    logic               shift_en;
    logic               scrolling;
    logic               recycle_valid;
    logic               recycle_ready;
    logic [2:0]         recycle_group;
    logic [14:0]        recycle_mask;
    logic               overrun;
`ifdef SCROLL_STATS_EN
    logic [15:0]        scroll_count;
`endif

    always #5 clk = ~clk;

    scroll_scheduler #(
        .FRAMES_PER_SCROLL(F),
        .GROUPS(G),
        .EARTH(768)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .move_collision(move_collision),
        .group_y(group_y),
        .rnd(rnd),
        .rnd_valid(rnd_valid),
        .shift_en(shift_en),
        .scrolling(scrolling),
        .recycle_valid(recycle_valid),
        .recycle_ready(recycle_ready),
        .recycle_group(recycle_group),
        .recycle_mask(recycle_mask),
        .overrun(overrun)
`ifdef SCROLL_STATS_EN
        ,
        .scroll_count(scroll_count)
`endif
    );

    typedef struct {
        logic [2:0]  grp;
        logic [14:0] mask;
    } req_t;

    typedef struct {
        int                 grp;      // group whose y is overridden
        logic signed [10:0] y;        // value placed on that group
        logic [14:0]        rnd;      // LFSR value presented
        bit                 exp_req;  // a request is expected
        logic [14:0]        exp_mask; // expected mask for that request
    } rec_vec_t;

    req_t rec_q[$];
    bit   sh_q[$];
    bit   sc_q[$];

    int checks   = 0;
    int failures = 0;
    int fl_m     = 0;   // frames left, reference model
    int trig_m   = 0;   // triggers seen by the reference model
    int pulses   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic base_y();
        for (int i = 0; i < G; i++) group_y[i] = 11'(-200 + i * 150);
    endtask

    task automatic push_req(input int g, input logic [14:0] m);
        req_t r;
        r.grp  = 3'(g);
        r.mask = m;
        rec_q.push_back(r);
    endtask

    // One clock: queue the scroll expectation, advance, then compare.
    task automatic step();
        bit   e_sh;
        bit   hs;
        req_t got;
        req_t want;
        e_sh = 1'b0;
        if (frame_tick) begin
            if (fl_m != 0) begin
                e_sh = 1'b1;
                fl_m--;
            end else if (move_collision) begin
                e_sh = 1'b1;
                fl_m = F - 1;
                trig_m++;
            end
        end
        sh_q.push_back(e_sh);
        sc_q.push_back(fl_m != 0);
        hs       = recycle_valid && recycle_ready;
        got.grp  = recycle_group;
        got.mask = recycle_mask;
        @(posedge clk);
        #1;
        check("shift_en", 32'(shift_en), 32'(sh_q.pop_front()));
        check("scrolling", 32'(scrolling), 32'(sc_q.pop_front()));
        if (shift_en) pulses++;
        if (hs) begin
            check("req_expected", 32'(rec_q.size() != 0), 32'd1);
            if (rec_q.size() != 0) begin
                want = rec_q.pop_front();
                $display("handshake group=%0d mask=%h (want %0d/%h)", got.grp, got.mask, want.grp, want.mask);
                check("req_group", 32'(got.grp), 32'(want.grp));
                check("req_mask", 32'(got.mask), 32'(want.mask));
            end
        end
        frame_tick = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic tick(input bit mc);
        move_collision = mc;
        frame_tick     = 1'b1;
        step();
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !recycle_valid; i++) step();
        check(name, 32'(recycle_valid), 32'd1);
    endtask

    // Asynchronous reset asserted mid-cycle. Outputs must clear without an edge.
    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        check("rst_shift_en", 32'(shift_en), 32'd0);
        check("rst_scrolling", 32'(scrolling), 32'd0);
        check("rst_valid", 32'(recycle_valid), 32'd0);
        check("rst_group", 32'(recycle_group), 32'd0);
        check("rst_mask", 32'(recycle_mask), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rec_q.delete();
        fl_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    rec_vec_t vecs [7];

    initial begin
        vecs[0] = '{2, 11'sd770,  15'h1234, 1'b1, 15'h1234};
        vecs[1] = '{0, 11'sd768,  15'h0000, 1'b1, 15'h4000};
        vecs[2] = '{5, 11'sd1023, 15'h7FFF, 1'b1, 15'h7FFF};
        vecs[3] = '{3, 11'sd767,  15'h0F0F, 1'b0, 15'h0000};
        vecs[4] = '{1, -11'sd1,   15'h0F0F, 1'b0, 15'h0000};
        vecs[5] = '{4, 11'sd900,  15'h0001, 1'b1, 15'h0001};
        vecs[6] = '{1, -11'sd1024, 15'h5555, 1'b0, 15'h0000};

        rst            = 1'b0;
        frame_tick     = 1'b0;
        move_collision = 1'b0;
        rnd            = 15'h0000;
        rnd_valid      = 1'b0;
        recycle_ready  = 1'b0;
        base_y();
        #12;
        check("init_shift_en", 32'(shift_en), 32'd0);
        check("init_scrolling", 32'(scrolling), 32'd0);
        check("init_valid", 32'(recycle_valid), 32'd0);
        check("init_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(3);

        // Single trigger followed by 20 plain ticks: exactly F pulses.
        pulses = 0;
        tick(1'b1);
        move_collision = 1'b0;
        run(9);
        repeat (20) begin
            tick(1'b0);
            run(9);
        end
        check("single_trigger_pulses", 32'(pulses), 32'(F));
        check("single_trigger_scroll_end", 32'(scrolling), 32'd0);
        check("no_overrun", 32'(overrun), 32'd0);

        // Collision held on every tick: no restart until the scroll drains.
        pulses = 0;
        repeat (F) begin
            tick(1'b1);
            run(9);
        end
        check("held_collision_pulses", 32'(pulses), 32'(F));
        check("held_collision_drained", 32'(scrolling), 32'd0);
        tick(1'b1);
        check("held_collision_restart", 32'(scrolling), 32'd1);
        move_collision = 1'b0;
        run(4);
        do_reset();     // mid-scroll abort
        run(6);         // no pulse expected without a tick

        // Table-driven single-scan recycle vectors.
        rnd_valid     = 1'b1;
        recycle_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            base_y();
            group_y[vecs[v].grp] = vecs[v].y;
            rnd = vecs[v].rnd;
            if (vecs[v].exp_req) push_req(vecs[v].grp, vecs[v].exp_mask);
            tick(1'b0);
            run(15);
            check("vec_reqs_left", 32'(rec_q.size()), 32'd0);
        end

        // Two groups down in one scan: served in index order.
        base_y();
        group_y[1] = 11'sd800;
        group_y[3] = 11'sd768;
        rnd = 15'h0ABC;
        push_req(1, 15'h0ABC);
        push_req(3, 15'h0ABC);
        tick(1'b0);
        run(20);
        check("multi_reqs_left", 32'(rec_q.size()), 32'd0);

        // WAIT_RND holds without rnd_valid, then stall with ready low.
        base_y();
        group_y[0]    = 11'sd768;
        rnd_valid     = 1'b0;
        recycle_ready = 1'b0;
        rnd           = 15'h0000;
        push_req(0, 15'h4000);
        tick(1'b0);
        run(12);
        check("wait_rnd_hold", 32'(recycle_valid), 32'd0);
        rnd_valid = 1'b1;
        wait_valid("stall_valid_seen");
        rnd = 15'h3333;  // must not disturb the latched mask
        repeat (5) begin
            step();
            check("stall_valid", 32'(recycle_valid), 32'd1);
            check("stall_group", 32'(recycle_group), 32'd0);
            check("stall_mask", 32'(recycle_mask), 32'h4000);
        end
        check("pre_overrun", 32'(overrun), 32'd0);

        // Tick during ISSUE coinciding with the handshake and a scroll trigger.
        recycle_ready = 1'b1;
        tick(1'b1);
        move_collision = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        run(20);        // group 0 still down: a second scan would show up here
        check("overrun_no_rescan", 32'(rec_q.size()), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("trigger_during_issue", 32'(scrolling), 32'd1);

        // Reset in the middle of a stalled ISSUE.
        do_reset();
        recycle_ready = 1'b0;
        rnd = 15'h0055;
        push_req(0, 15'h0055);
        tick(1'b0);
        wait_valid("abort_valid_seen");
        do_reset();
        recycle_ready = 1'b1;
        run(10);
        check("abort_no_req", 32'(recycle_valid), 32'd0);

`ifdef SCROLL_STATS_EN
        check("scroll_count", 32'(scroll_count), 32'(trig_m));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scroll_scheduler.md
SCROLL_SCHEDULER -- requirements
Module: scroll_scheduler

Interface
REQ-001 SHALL have parameter FRAMES_PER_SCROLL, default 16: frames a world scroll lasts once triggered (2..16).
REQ-002 SHALL have parameter GROUPS, default 6: platform row groups scanned for recycling (1..8).
REQ-003 SHALL have parameter EARTH, default 768: signed y at or beyond which a group is recycled.
REQ-004 SHALL have port clk  in  1  single system clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse at end of each frame.
REQ-007 SHALL have port move_collision  in  1  doodle landed high enough to start a scroll; sampled only on frame_tick.
REQ-008 SHALL have port group_y  in  GROUPS x 11 signed  current y of each group's first platform.
REQ-009 SHALL have port rnd, rnd_valid  in  15 / 1  random pattern from LFSR and its valid flag.
REQ-010 SHALL have port shift_en  out  1  one-cycle pulse: platform datapath adds WORLD_SHIFT this frame.
REQ-011 SHALL have port scrolling  out  1  high while a scroll is in progress.
REQ-012 SHALL have port recycle_valid, recycle_ready  out/in  1/1  recycle request handshake.
REQ-013 SHALL have port recycle_group, recycle_mask  out  3 / 15  group index and its new activation pattern.
REQ-014 SHALL have port overrun  out  1  sticky: frame_tick arrived while recycle FSM busy.

Function
REQ-015 Scroll: on frame_tick with frames_left==0 and move_collision, shift_en SHALL pulse next cycle and frames_left SHALL load FRAMES_PER_SCROLL-1.
REQ-016 On frame_tick with frames_left!=0, shift_en SHALL pulse next cycle and frames_left SHALL decrement; move_collision SHALL be ignored (no restart).
REQ-017 scrolling SHALL equal (frames_left!=0); total shift_en pulses per trigger SHALL be exactly FRAMES_PER_SCROLL.
REQ-018 Recycle FSM states SHALL be IDLE, SCAN, WAIT_RND, ISSUE.
REQ-019 IDLE->SCAN on frame_tick, idx=0; group_y SHALL be sampled no earlier than 2 cycles after frame_tick so a same-frame shift is visible.
REQ-020 SCAN: one group per cycle; signed group_y[idx]>=EARTH -> WAIT_RND; else idx+1; after idx==GROUPS-1 -> IDLE.
REQ-021 WAIT_RND: on rnd_valid latch mask=rnd, but if rnd==0 mask SHALL be 15'h4000; -> ISSUE.
REQ-022 ISSUE: recycle_valid high, group and mask stable until recycle_ready; on valid&ready, idx+1 -> SCAN, or IDLE if idx was last.
REQ-023 recycle_valid SHALL never drop without ready; at most one request per group per scan.
REQ-024 frame_tick while FSM not IDLE SHALL be dropped for recycling, set overrun, and still drive the scroll logic.
REQ-025 Scroll logic and recycle FSM SHALL operate independently; simultaneous frame_tick and handshake both complete.

Reset
REQ-026 On rst low (asynchronous): frames_left=0, shift_en=0, scrolling=0, FSM=IDLE, idx=0, recycle_valid=0, recycle_group=0, recycle_mask=0, overrun=0.
REQ-027 Reset mid-scroll or mid-handshake SHALL abort immediately; no pulse after release until next frame_tick.

Configuration
REQ-028 Macro SCROLL_STATS_EN defined: adds output scroll_count (16 bit) incrementing per scroll trigger, saturating at 16'hFFFF, reset 0.
REQ-029 Macro SCROLL_STATS_EN undefined: no scroll_count port and no counter logic; all other behaviour identical.

Verification
REQ-030 frame_tick+move_collision once, then 20 frame_ticks -> exactly 16 shift_en pulses, scrolling low after 16th.
REQ-031 move_collision held on every tick during scroll -> no restart; 16 pulses, new scroll starts on 17th tick.
REQ-032 group_y[2]=770, others <768, rnd=15'h1234 valid -> one request group=2, mask=15'h1234.
REQ-033 rnd=0 valid, group 0 at 768 -> mask=15'h4000; recycle_ready low 5 cycles -> valid, group, mask held stable.
REQ-034 frame_tick during ISSUE -> overrun=1, no second scan; rst low mid-ISSUE -> recycle_valid=0 asynchronously.
REQ-035 With SCROLL_STATS_EN, 3 triggered scrolls -> scroll_count=3.
